tx_pkt_arbiter: RTL and testbench
=================================

Name: tx_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single Darwin3 transmit path (the 16-bit AXI-Stream input of the toggle req/ack TX sender) between N_REQ packet sources (host DMA, config engine, spike injector, ...).
- Holds a grant for a whole packet, up to and including its TLAST beat.
- After a read packet (type 3'b010), the TX path stays blocked until the read response is reported received, or until a timeout expires.
- Sits between the requester FIFOs and the TX sender.

Parameters:
N_REQ, 4, number of requesting AXI-Stream sources (2..8)
DW, 16, flit width in bits
RD_TIMEOUT, 1024, cycles to wait for is_receive after a read packet before giving up (>=2)
MAX_FLITS, 16, flits per packet above which len_err is flagged

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  permits new grants; an in-flight packet always completes
s_tdata  in  N_REQ*DW  requester flits; requester i occupies bits [i*DW +: DW]
s_tvalid  in  N_REQ  requester valid
s_tlast  in  N_REQ  requester last flit of packet
s_tready  out  N_REQ  requester ready
m_tdata  out  DW  flit to TX sender
m_tvalid  out  1  valid to TX sender
m_tlast  out  1  last flit to TX sender
m_tready  in  1  ready from TX sender
is_receive  in  1  single-cycle pulse: read response fully received
grant_id  out  clog2(N_REQ)  index of current/last granted requester
busy  out  1  high in XFER or RD_WAIT
rd_timeout  out  1  1-cycle pulse: RD_WAIT expired
len_err  out  1  1-cycle pulse: packet exceeded MAX_FLITS

Behaviour:
- Reset values (asynchronous):
  - state=IDLE; s_tready=0; m_tvalid=0; m_tlast=0; m_tdata=0.
  - grant_id=0; busy=0; rd_timeout=0; len_err=0.
  - RR pointer=N_REQ-1, so requester 0 wins first.
- States: IDLE, XFER, RD_WAIT (one-hot or binary; implementer's choice).
- IDLE:
  - All s_tready=0; m_tvalid=0.
  - If enable and any s_tvalid: winner = first set bit searching from ptr+1 upward, wrapping modulo N_REQ.
  - Register grant_id=winner and ptr=winner; go to XFER next cycle. Arbitration latency is 1 cycle.
- XFER (combinational pass-through of the granted requester g):
  - m_tdata=s_tdata[g]; m_tvalid=s_tvalid[g]; m_tlast=s_tlast[g].
  - s_tready[g]=m_tready; all other s_tready=0.
  - Beat = m_tvalid && m_tready.
  - Flit counter (width clog2(MAX_FLITS+2)) clears on entry and increments per beat.
  - First beat: latch pkg_type = m_tdata[15:13].
  - Beat number MAX_FLITS+1 without TLAST: pulse len_err once per packet; transfer continues unchanged until TLAST. Counter saturates.
  - Beat with m_tlast: if latched type (or the current flit's [15:13] when it is a single-flit packet) == 3'b010, go to RD_WAIT; else go to IDLE.
- RD_WAIT:
  - m_tvalid=0; all s_tready=0; wait counter clears on entry.
  - is_receive=1: go to IDLE.
  - Counter == RD_TIMEOUT-1 without is_receive: pulse rd_timeout, go to IDLE.
  - is_receive in the same cycle as the timeout count: is_receive wins; no rd_timeout.
- is_receive outside RD_WAIT is ignored.
- Back-to-back packets: IDLE costs 1 bubble cycle between packets. The requester that just finished has lowest priority next round.
- enable dropped during XFER/RD_WAIT has no effect until the return to IDLE; no new grant while enable=0.
- s_tvalid dropping mid-packet: grant is held, idle beats allowed; no timeout in XFER.
- Reset mid-packet: immediate return to IDLE with all outputs at reset values. Partial packet downstream is the TX sender's concern.
- busy = (state != IDLE).

Test Plan:
- Single requester: req1 sends 4-flit packet 0x0000,0x1111,0x2222,0x3333 (last), m_tready=1 → grant_id=1 one cycle after valid; 4 beats on m_* in order; m_tlast on 4th; back to IDLE; busy low after.
- RR fairness: all 4 requesters hold 2-flit spike packets continuously → grant order 0,1,2,3,0; exactly 1 idle cycle between packets; no interleaving within a packet.
- Read blocking: req2 sends 4-flit packet, first flit 0x4000 (type 010) → RD_WAIT; req0 valid but not granted; is_receive pulse at cycle 50 → IDLE, then req0 granted next cycle.
- Read timeout (RD_TIMEOUT=16): read packet with no is_receive → rd_timeout single pulse 16 cycles after RD_WAIT entry, then next grant. Also is_receive coincident with count 15 → no rd_timeout.
- Backpressure/length: m_tready toggled 1/0 every cycle, 18-flit packet with MAX_FLITS=16 → all 18 flits delivered in order, none duplicated; len_err pulses once on beat 17.
- Reset/enable: assert rst_n low in the middle of XFER → all outputs 0 at once; after release req0 wins first. enable=0 with valid requests → no grant, busy=0.

Source files
------------

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter that shares the Darwin3 TX sender stream among N_REQ sources.
// A grant lasts through TLAST; read packets then block the path until is_receive or a timeout.
module tx_pkt_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DW         = 16,
  parameter int RD_TIMEOUT = 1024,
  parameter int MAX_FLITS  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_REQ*DW-1:0]      s_tdata,
  input  logic [N_REQ-1:0]         s_tvalid,
  input  logic [N_REQ-1:0]         s_tlast,
  output logic [N_REQ-1:0]         s_tready,
  output logic [DW-1:0]            m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  input  logic                     is_receive,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     rd_timeout,
  output logic                     len_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_FLITS + 2);
  localparam int TW = $clog2(RD_TIMEOUT);

  localparam logic [2:0]    RD_TYPE  = 3'b010;
  localparam logic [CW-1:0] CNT_LEN  = CW'(MAX_FLITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_FLITS + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] ptr_r;
  logic [IW-1:0] grant_r;
  logic [CW-1:0] flit_cnt_r;
  logic [TW-1:0] wait_cnt_r;
  logic [2:0]    pkt_type_r;
  logic          len_err_r;
  logic          rd_timeout_r;

  logic [IW-1:0] winner_s;
  logic          win_vld_s;
  logic          beat_s;
  logic          pkt_is_rd_s;
  logic          len_err_s;
  logic          tmo_s;
  logic [DW-1:0] req_data_s [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_data_s[gi] = s_tdata[gi*DW +: DW];
  end

  // Requester index k positions after base, wrapping modulo N_REQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % N_REQ;
    return sum[IW-1:0];
  endfunction

  // Round-robin search from ptr+1; scanning downward lets the nearest valid requester win.
  always_comb begin
    winner_s  = ptr_r;
    win_vld_s = |s_tvalid;
    for (int k = N_REQ; k >= 1; k--) begin
      winner_s = s_tvalid[rr_idx(ptr_r, k)] ? rr_idx(ptr_r, k) : winner_s;
    end
  end

  // Next state, stream pass-through and single-cycle event detection.
  always_comb begin
    state_s     = state_r;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    s_tready    = '0;
    beat_s      = 1'b0;
    pkt_is_rd_s = 1'b0;
    len_err_s   = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && win_vld_s) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        m_tdata           = req_data_s[grant_r];
        m_tvalid          = s_tvalid[grant_r];
        m_tlast           = s_tlast[grant_r];
        s_tready[grant_r] = m_tready;
        beat_s            = s_tvalid[grant_r] && m_tready;
        // A single-flit packet has not latched its type yet, so use the live flit.
        pkt_is_rd_s = (((flit_cnt_r == '0) ? m_tdata[DW-1 -: 3] : pkt_type_r) == RD_TYPE);
        len_err_s   = beat_s && !m_tlast && (flit_cnt_r == CNT_LEN);
        if (beat_s && m_tlast) begin
          if (pkt_is_rd_s) begin
            state_s = ST_RD_WAIT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_RD_WAIT: begin
        tmo_s = !is_receive && (wait_cnt_r == TMO_LAST);
        if (is_receive || (wait_cnt_r == TMO_LAST)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, grant/pointer, flit and wait counters, and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ptr_r        <= IW'(N_REQ - 1);
      grant_r      <= '0;
      flit_cnt_r   <= '0;
      wait_cnt_r   <= '0;
      pkt_type_r   <= 3'b000;
      len_err_r    <= 1'b0;
      rd_timeout_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_err_r    <= len_err_s;
      rd_timeout_r <= tmo_s;
      case (state_r)
        ST_IDLE: begin
          flit_cnt_r <= '0;
          wait_cnt_r <= '0;
          if (enable && win_vld_s) begin
            grant_r <= winner_s;
            ptr_r   <= winner_s;
          end
        end
        ST_XFER: begin
          wait_cnt_r <= '0;
          if (beat_s) begin
            if (flit_cnt_r == '0) begin
              pkt_type_r <= m_tdata[DW-1 -: 3];
            end
            if (flit_cnt_r != CNT_SAT) begin
              flit_cnt_r <= flit_cnt_r + CNT_ONE;
            end
          end
        end
        ST_RD_WAIT: begin
          if (!is_receive && (wait_cnt_r != TMO_LAST)) begin
            wait_cnt_r <= wait_cnt_r + TMO_ONE;
          end
        end
        default: begin
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

  assign grant_id   = grant_r;
  assign busy       = (state_r != ST_IDLE);
  assign rd_timeout = rd_timeout_r;
  assign len_err    = len_err_r;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed bench for tx_pkt_arbiter: single packet, round-robin order, read blocking/timeout,
// backpressure with an over-length packet, mid-packet reset and enable gating.
module tb_tx_pkt_arbiter;

  localparam int N_REQ      = 4;
  localparam int DW         = 16;
  localparam int RD_TIMEOUT = 16;
  localparam int MAX_FLITS  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic [N_REQ*DW-1:0] s_tdata;
  logic [N_REQ-1:0]    s_tvalid;
  logic [N_REQ-1:0]    s_tlast;
  logic [N_REQ-1:0]    s_tready;
  logic [DW-1:0]       m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic                m_tready;
  logic                is_receive;
  logic [1:0]          grant_id;
  logic                busy;
  logic                rd_timeout;
  logic                len_err;

  logic [DW-1:0] req_data [N_REQ];
  int errors = 0;
  int checks = 0;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pack
    assign s_tdata[gi*DW +: DW] = req_data[gi];
  end

  tx_pkt_arbiter #(
    .N_REQ(N_REQ), .DW(DW), .RD_TIMEOUT(RD_TIMEOUT), .MAX_FLITS(MAX_FLITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .is_receive(is_receive), .grant_id(grant_id), .busy(busy),
    .rd_timeout(rd_timeout), .len_err(len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic [15:0] d, input logic v, input logic l);
    req_data[i] = d;
    s_tvalid[i] = v;
    s_tlast[i]  = l;
  endtask

  initial begin
    logic [3:0] fire;
    int         cnt [N_REQ];
    int         recv;
    int         sidx;
    int         len_cnt;
    logic       exp_len;
    logic       done;
    logic       src_fire;

    rst_n      = 1'b0;
    enable     = 1'b1;
    m_tready   = 1'b1;
    is_receive = 1'b0;
    s_tvalid   = 4'b0000;
    s_tlast    = 4'b0000;
    for (int i = 0; i < N_REQ; i++) req_data[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_mvalid", 32'(m_tvalid), 32'h0);
    check("rst_mlast", 32'(m_tlast), 32'h0);
    check("rst_mdata", 32'(m_tdata), 32'h0);
    check("rst_sready", 32'(s_tready), 32'h0);
    check("rst_rdto", 32'(rd_timeout), 32'h0);
    check("rst_lenerr", 32'(len_err), 32'h0);
    rst_n = 1'b1;

    // Single requester: 4-flit packet from req1
    next_cyc();
    set_req(2'd1, 16'h0000, 1'b1, 1'b0);
    settle();
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_idle_sready", 32'(s_tready), 32'h0);
    next_cyc();
    settle();
    check("t1_grant", 32'(grant_id), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_sready", 32'(s_tready), 32'h2);
    check("t1_mvalid", 32'(m_tvalid), 32'h1);
    check("t1_data0", 32'(m_tdata), 32'h0000);
    check("t1_last0", 32'(m_tlast), 32'h0);
    for (int k = 1; k < 4; k++) begin
      next_cyc();
      set_req(2'd1, 16'h1111 * 16'(k), 1'b1, (k == 3));
      settle();
      check("t1_data", 32'(m_tdata), 32'h1111 * 32'(k));
      check("t1_last", 32'(m_tlast), 32'(k == 3));
    end
    next_cyc();
    set_req(2'd1, 16'h0000, 1'b0, 1'b0);
    settle();
    check("t1_end_busy", 32'(busy), 32'h0);
    check("t1_end_mvalid", 32'(m_tvalid), 32'h0);

    // Round robin: all four hold 2-flit packets; fresh reset so req0 wins first
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      cnt[i] = 0;
      set_req(2'(i), 16'h1000 + 16'(i * 16), 1'b1, 1'b0);
    end
    settle();
    for (int c = 0; c < 15; c++) begin
      int ph;
      int g;
      ph = c % 3;
      g  = (c / 3) % 4;
      if (ph == 0) begin
        check("t2_gap_busy", 32'(busy), 32'h0);
        check("t2_gap_mvalid", 32'(m_tvalid), 32'h0);
      end else begin
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_grant", 32'(grant_id), 32'(g));
        check("t2_data", 32'(m_tdata), 32'h1000 + 32'(g * 16 + ph - 1));
        check("t2_last", 32'(m_tlast), 32'(ph == 2));
        check("t2_sready", 32'(s_tready), 32'(1 << g));
      end
      fire = s_tready & s_tvalid;
      next_cyc();
      for (int i = 0; i < N_REQ; i++) begin
        if (fire[i]) cnt[i] = 1 - cnt[i];
        set_req(2'(i), 16'h1000 + 16'(i * 16 + cnt[i]), 1'b1, (cnt[i] == 1));
      end
      settle();
    end
    s_tvalid = 4'b0000;
    s_tlast  = 4'b0000;

    // Read blocking: req2 sends a read packet; req0 waits until is_receive
    next_cyc();
    set_req(2'd2, 16'h4000, 1'b1, 1'b0);
    set_req(2'd0, 16'h1234, 1'b1, 1'b1);
    settle();
    check("t3_idle_busy", 32'(busy), 32'h0);
    next_cyc();
    settle();
    check("t3_grant", 32'(grant_id), 32'h2);
    check("t3_data0", 32'(m_tdata), 32'h4000);
    check("t3_sready", 32'(s_tready), 32'h4);
    for (int k = 1; k < 4; k++) begin
      next_cyc();
      set_req(2'd2, 16'h4000 + 16'(k), 1'b1, (k == 3));
      is_receive = (k == 1);
      settle();
      check("t3_data", 32'(m_tdata), 32'h4000 + 32'(k));
    end
    next_cyc();
    is_receive = 1'b0;
    set_req(2'd2, 16'h0000, 1'b0, 1'b0);
    settle();
    check("t3_wait_busy", 32'(busy), 32'h1);
    check("t3_wait_mvalid", 32'(m_tvalid), 32'h0);
    check("t3_wait_sready", 32'(s_tready), 32'h0);
    for (int w = 1; w <= 8; w++) begin
      next_cyc();
      is_receive = (w == 8);
      settle();
      check("t3_wait_hold", 32'(busy), 32'h1);
      check("t3_wait_rdto", 32'(rd_timeout), 32'h0);
    end
    next_cyc();
    is_receive = 1'b0;
    settle();
    check("t3_rcv_idle", 32'(busy), 32'h0);
    check("t3_rcv_rdto", 32'(rd_timeout), 32'h0);
    next_cyc();
    settle();
    check("t3_req0_grant", 32'(grant_id), 32'h0);
    check("t3_req0_data", 32'(m_tdata), 32'h1234);
    check("t3_req0_last", 32'(m_tlast), 32'h1);
    next_cyc();
    set_req(2'd0, 16'h0000, 1'b0, 1'b0);
    settle();
    check("t3_end_busy", 32'(busy), 32'h0);

    // Read timeout: single-flit read from req1, no is_receive; req3 queued behind it
    set_req(2'd1, 16'h4000, 1'b1, 1'b1);
    set_req(2'd3, 16'h1333, 1'b1, 1'b1);
    settle();
    next_cyc();
    settle();
    check("t4_grant", 32'(grant_id), 32'h1);
    check("t4_last", 32'(m_tlast), 32'h1);
    next_cyc();
    set_req(2'd1, 16'h0000, 1'b0, 1'b0);
    settle();
    check("t4_wait_entry", 32'(busy), 32'h1);
    for (int c = 3; c <= 17; c++) begin
      next_cyc();
      settle();
      check("t4_wait_busy", 32'(busy), 32'h1);
      check("t4_wait_rdto", 32'(rd_timeout), 32'h0);
    end
    next_cyc();
    settle();
    check("t4_rdto_pulse", 32'(rd_timeout), 32'h1);
    check("t4_rdto_idle", 32'(busy), 32'h0);
    next_cyc();
    settle();
    check("t4_rdto_single", 32'(rd_timeout), 32'h0);
    check("t4_next_grant", 32'(grant_id), 32'h3);
    check("t4_next_data", 32'(m_tdata), 32'h1333);
    next_cyc();
    set_req(2'd3, 16'h0000, 1'b0, 1'b0);
    settle();

    // is_receive coincident with the final wait count suppresses rd_timeout
    set_req(2'd0, 16'h4abc, 1'b1, 1'b1);
    settle();
    next_cyc();
    settle();
    check("t4b_grant", 32'(grant_id), 32'h0);
    next_cyc();
    set_req(2'd0, 16'h0000, 1'b0, 1'b0);
    settle();
    for (int c = 3; c <= 16; c++) begin
      next_cyc();
      settle();
    end
    next_cyc();
    is_receive = 1'b1;
    settle();
    check("t4b_last_wait", 32'(busy), 32'h1);
    next_cyc();
    is_receive = 1'b0;
    settle();
    check("t4b_no_rdto", 32'(rd_timeout), 32'h0);
    check("t4b_idle", 32'(busy), 32'h0);
    next_cyc();
    settle();
    check("t4b_no_rdto_late", 32'(rd_timeout), 32'h0);

    // Backpressure + over-length: 18 flits from req1 with m_tready toggling
    sidx     = 0;
    recv     = 0;
    len_cnt  = 0;
    exp_len  = 1'b0;
    done     = 1'b0;
    m_tready = 1'b0;
    set_req(2'd1, 16'h2000, 1'b1, 1'b0);
    settle();
    for (int c = 0; c < 80; c++) begin
      if (!done) begin
        check("t5_lenerr", 32'(len_err), 32'(exp_len));
        if (len_err) len_cnt++;
        exp_len = 1'b0;
        if (m_tvalid && m_tready) begin
          check("t5_data", 32'(m_tdata), 32'h2000 + 32'(recv));
          check("t5_last", 32'(m_tlast), 32'(recv == 17));
          recv++;
          if (recv == MAX_FLITS + 1) exp_len = 1'b1;
          if (m_tlast) done = 1'b1;
        end
        src_fire = s_tready[1] && s_tvalid[1];
        next_cyc();
        if (src_fire) sidx++;
        m_tready = ~m_tready;
        if (sidx < 18) begin
          set_req(2'd1, 16'h2000 + 16'(sidx), 1'b1, (sidx == 17));
        end else begin
          set_req(2'd1, 16'h0000, 1'b0, 1'b0);
        end
        settle();
      end
    end
    check("t5_done", 32'(done), 32'h1);
    check("t5_count", 32'(recv), 32'd18);
    check("t5_lenerr_once", 32'(len_cnt), 32'h1);
    check("t5_lenerr_after", 32'(len_err), 32'h0);
    m_tready = 1'b1;

    // Reset in the middle of a packet from req2
    set_req(2'd2, 16'h1000, 1'b1, 1'b0);
    settle();
    next_cyc();
    settle();
    check("t6_grant", 32'(grant_id), 32'h2);
    next_cyc();
    set_req(2'd2, 16'h1001, 1'b1, 1'b0);
    settle();
    check("t6_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_mvalid", 32'(m_tvalid), 32'h0);
    check("t6_rst_mdata", 32'(m_tdata), 32'h0);
    check("t6_rst_sready", 32'(s_tready), 32'h0);
    check("t6_rst_grant", 32'(grant_id), 32'h0);
    #1;
    rst_n = 1'b1;
    set_req(2'd0, 16'h1777, 1'b1, 1'b1);
    next_cyc();
    settle();
    check("t6_req0_first", 32'(grant_id), 32'h0);
    check("t6_req0_data", 32'(m_tdata), 32'h1777);
    next_cyc();
    set_req(2'd0, 16'h0000, 1'b0, 1'b0);
    set_req(2'd2, 16'h0000, 1'b0, 1'b0);
    settle();

    // enable=0 blocks new grants; dropping it mid-packet lets the packet finish
    enable = 1'b0;
    set_req(2'd1, 16'h1111, 1'b1, 1'b1);
    set_req(2'd3, 16'h1333, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      settle();
      check("t7_dis_busy", 32'(busy), 32'h0);
      check("t7_dis_sready", 32'(s_tready), 32'h0);
    end
    enable = 1'b1;
    next_cyc();
    enable = 1'b0;
    settle();
    check("t7_en_grant", 32'(grant_id), 32'h1);
    check("t7_en_mvalid", 32'(m_tvalid), 32'h1);
    next_cyc();
    set_req(2'd1, 16'h0000, 1'b0, 1'b0);
    settle();
    next_cyc();
    settle();
    check("t7_dis_after", 32'(busy), 32'h0);
    s_tvalid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
